demux1x2_stream: RTL and testbench
==================================

DEMUX1X2_STREAM -- requirements
Module: demux1x2_stream

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clrn  input  1  asynchronous, active-low reset (clear).
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_sel  input  1  destination of the offered word: 0 routes to channel 0, 1 routes to channel 1.
REQ-006 in_data  input  WIDTH  upstream word.
REQ-007 in_ready  output  1  block can accept the offered word this cycle.
REQ-008 out0_valid, out1_valid  output  1 each  channel holds a word.
REQ-009 out0_data, out1_data  output  WIDTH each  head word of the channel.
REQ-010 out0_ready, out1_ready  input  1 each  downstream consumes the head word.
REQ-011 cnt0, cnt1  output  8 each  count of words accepted into each channel, modulo 256.

Function
REQ-012 Each channel SHALL contain an independent 2-entry FIFO built from read pointer, write pointer and a 2-bit occupancy count (0..2).
REQ-013 A push SHALL occur when in_valid & in_ready; the word SHALL be written only into the FIFO selected by in_sel.
REQ-014 in_ready SHALL be combinationally equal to "selected channel occupancy < 2"; it SHALL NOT depend on outN_ready (no pass-through while full).
REQ-015 outN_valid SHALL be 1 iff channel N occupancy > 0; outN_data SHALL be the oldest stored word of channel N.
REQ-016 A pop of channel N SHALL occur when outN_valid & outN_ready; outN_ready while outN_valid=0 SHALL have no effect.
REQ-017 Latency: a word pushed at edge k SHALL appear on outN_data with outN_valid=1 after edge k (visible in cycle k+1); there is no same-cycle bypass.
REQ-018 Order within a channel SHALL be preserved; the two channels SHALL NOT block each other (a full channel 0 SHALL NOT stall words destined to channel 1).
REQ-019 Simultaneous push and pop on the same channel with occupancy 1 SHALL leave occupancy 1 and update both pointers.
REQ-020 Simultaneous push and pop on the same channel with occupancy 2 SHALL NOT occur (in_ready=0); only the pop is performed, occupancy becomes 1.
REQ-021 Pop on one channel and push on the other in the same cycle SHALL both complete.
REQ-022 Pointers SHALL be 1 bit and wrap 1 -> 0.
REQ-023 cntN SHALL increment by 1 on each push into channel N and wrap 255 -> 0.
REQ-024 outN_data while outN_valid=0 is don't-care; words SHALL never be duplicated or dropped.

Reset
REQ-025 clrn=0 SHALL immediately, without waiting for clk, clear all pointers, occupancies and counters: out0_valid=0, out1_valid=0, in_ready=1, cnt0=0, cnt1=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; the first push after release (first rising edge with clrn=1) SHALL be handled as into empty FIFOs.
REQ-027 Stored data registers need not be reset.

Verification
REQ-028 Basic routing: after reset, push 0xA5A5A5A5 sel=0 then 0x5A5A5A5A sel=1, outputs not ready -> out0_data=0xA5A5A5A5, out1_data=0x5A5A5A5A, both valid, cnt0=1, cnt1=1.
REQ-029 Full/backpressure: three pushes sel=0 (0x1,0x2,0x3) with out0_ready=0 -> in_ready=0 during the third offer while sel=0; raise out0_ready -> 0x1 then 0x2 popped in order, third word then accepted.
REQ-030 Non-blocking: channel 0 full, offer 0x7 sel=1 -> in_ready=1, word accepted, out1_valid=1 next cycle.
REQ-031 Simultaneous push/pop: channel 1 holding 0x10, push 0x11 sel=1 while out1_ready=1 -> 0x10 consumed, occupancy stays 1, out1_data=0x11.
REQ-032 Counter wrap: 256 pushes sel=0 with out0_ready=1 -> cnt0 returns to 0, cnt1 remains 0, no word lost.
REQ-033 Asynchronous reset: with both channels full, drop clrn between edges -> out0_valid=out1_valid=0 and cnt0=cnt1=0 immediately, in_ready=1.

Source files
------------

// File: rtl/demux1x2_stream_if.sv
// Handshake bundle for the 1-to-2 stream demultiplexer.
// The upstream/downstream agent uses master; the demux uses slave.
interface demux1x2_stream_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out0_valid;
   logic             out1_valid;
   logic [WIDTH-1:0] out0_data;
   logic [WIDTH-1:0] out1_data;
   logic             out0_ready;
   logic             out1_ready;
   logic [7:0]       cnt0;
   logic [7:0]       cnt1;

   modport master (
      output in_valid, in_sel, in_data, out0_ready, out1_ready,
      input  in_ready, out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1
   );

   modport slave (
      input  in_valid, in_sel, in_data, out0_ready, out1_ready,
      output in_ready, out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1
   );
endinterface

// File: rtl/demux1x2_stream.sv
// Routes one upstream stream into two independent 2-entry FIFOs selected by in_sel,
// with a per-channel modulo-256 accepted-word counter.
module demux1x2_stream #(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              clrn,
   demux1x2_stream_if.slave bus
);
   logic [WIDTH-1:0] mem [2][2];
   logic [1:0]       rptr;
   logic [1:0]       wptr;
   logic [1:0]       occ [2];
   logic [7:0]       cnt [2];
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       out_ready;
   logic             accept;

   // in_ready looks only at the selected channel's occupancy, never at downstream ready
   always_comb begin
      out_ready[0] = bus.out0_ready;
      out_ready[1] = bus.out1_ready;
      accept       = (occ[bus.in_sel] < 2'd2);
      bus.in_ready = accept;
      for (int c = 0; c < 2; c++) begin
         push[c] = bus.in_valid && accept && (int'(bus.in_sel) == c);
         pop[c]  = (occ[c] != 2'd0) && out_ready[c];
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rptr <= '0;
         wptr <= '0;
         for (int c = 0; c < 2; c++) begin
            occ[c] <= '0;
            cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
               wptr[c] <= ~wptr[c];
               cnt[c]  <= cnt[c] + 8'd1;
            end
            if (pop[c]) begin
               rptr[c] <= ~rptr[c];
            end
            case ({push[c], pop[c]})
               2'b10:   occ[c] <= occ[c] + 2'd1;
               2'b01:   occ[c] <= occ[c] - 2'd1;
               default: occ[c] <= occ[c];
            endcase
         end
      end
   end

   // Storage carries no reset; occupancy alone decides what is meaningful
   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (push[c]) begin
            mem[c][wptr[c]] <= bus.in_data;
         end
      end
   end

   assign bus.out0_valid = (occ[0] != 2'd0);
   assign bus.out1_valid = (occ[1] != 2'd0);
   assign bus.out0_data  = mem[0][rptr[0]];
   assign bus.out1_data  = mem[1][rptr[1]];
   assign bus.cnt0       = cnt[0];
   assign bus.cnt1       = cnt[1];
endmodule

// File: tb/tb_demux1x2_stream.sv
// Self-checking bench for demux1x2_stream: directed vector table, queue-based
// reference model under random traffic, counter wrap and asynchronous reset cases.
module tb_demux1x2_stream;
   logic clk;
   logic clrn;

   demux1x2_stream_if #(.WIDTH(32)) bus ();

   demux1x2_stream #(.WIDTH(32)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        iv;
      logic        sel;
      logic [31:0] d;
      logic        r0;
      logic        r1;
      logic        e_rdy;
      logic        e_v0;
      logic        e_v1;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic [7:0]  e_c0;
      logic [7:0]  e_c1;
   } vec_t;

   vec_t        vecs [18];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [7:0]  m_cnt0;
   logic [7:0]  m_cnt1;
   int          dut_pops0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic sel, input logic [31:0] d,
                                input logic r0, input logic r1);
      bus.in_valid   = iv;
      bus.in_sel     = sel;
      bus.in_data    = d;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
   endtask

   task automatic clearModel();
      q0.delete();
      q1.delete();
      m_cnt0    = 8'd0;
      m_cnt1    = 8'd0;
      dut_pops0 = 0;
   endtask

   // One clock of checking against the queue model, then advance the model on the edge
   task automatic modelCycle();
      logic p0, p1, acc;
      @(negedge clk);
      acc = bus.in_sel ? (q1.size() < 2) : (q0.size() < 2);
      checkOutput("in_ready", 32'(bus.in_ready), 32'(acc));
      checkOutput("out0_valid", 32'(bus.out0_valid), 32'(q0.size() > 0));
      checkOutput("out1_valid", 32'(bus.out1_valid), 32'(q1.size() > 0));
      if (q0.size() > 0) checkOutput("out0_data", bus.out0_data, q0[0]);
      if (q1.size() > 0) checkOutput("out1_data", bus.out1_data, q1[0]);
      checkOutput("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
      checkOutput("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
      if (bus.out0_valid && bus.out0_ready) dut_pops0++;
      p0 = (q0.size() > 0) && bus.out0_ready;
      p1 = (q1.size() > 0) && bus.out1_ready;
      @(posedge clk);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (bus.in_valid && acc) begin
         if (bus.in_sel) begin
            q1.push_back(bus.in_data);
            m_cnt1 = m_cnt1 + 8'd1;
         end else begin
            q0.push_back(bus.in_data);
            m_cnt0 = m_cnt0 + 8'd1;
         end
      end
      #1;
   endtask

   task automatic doReset();
      clrn = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
      checkOutput("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
      checkOutput("rst_cnt0", 32'(bus.cnt0), 32'd0);
      checkOutput("rst_cnt1", 32'(bus.cnt1), 32'd0);
      @(negedge clk);
      clrn = 1'b1;
      clearModel();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // iv sel data r0 r1 | rdy v0 v1 d0 d1 cnt0 cnt1 (outputs seen before the edge)
      vecs[0]  = '{1, 0, 32'hA5A5A5A5, 0, 0, 1, 0, 0, 32'h0,        32'h0,        8'd0, 8'd0};
      vecs[1]  = '{1, 1, 32'h5A5A5A5A, 0, 0, 1, 1, 0, 32'hA5A5A5A5, 32'h0,        8'd1, 8'd0};
      vecs[2]  = '{0, 0, 32'h0,        0, 0, 1, 1, 1, 32'hA5A5A5A5, 32'h5A5A5A5A, 8'd1, 8'd1};
      vecs[3]  = '{0, 0, 32'h0,        1, 1, 1, 1, 1, 32'hA5A5A5A5, 32'h5A5A5A5A, 8'd1, 8'd1};
      vecs[4]  = '{0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        8'd1, 8'd1};
      vecs[5]  = '{1, 0, 32'h1,        0, 0, 1, 0, 0, 32'h0,        32'h0,        8'd1, 8'd1};
      vecs[6]  = '{1, 0, 32'h2,        0, 0, 1, 1, 0, 32'h1,        32'h0,        8'd2, 8'd1};
      vecs[7]  = '{1, 0, 32'h3,        0, 0, 0, 1, 0, 32'h1,        32'h0,        8'd3, 8'd1};
      vecs[8]  = '{1, 1, 32'h7,        0, 0, 1, 1, 0, 32'h1,        32'h0,        8'd3, 8'd1};
      vecs[9]  = '{1, 0, 32'h3,        1, 0, 0, 1, 1, 32'h1,        32'h7,        8'd3, 8'd2};
      vecs[10] = '{1, 0, 32'h3,        1, 0, 1, 1, 1, 32'h2,        32'h7,        8'd3, 8'd2};
      vecs[11] = '{0, 0, 32'h0,        1, 0, 1, 1, 1, 32'h3,        32'h7,        8'd4, 8'd2};
      vecs[12] = '{0, 0, 32'h0,        0, 1, 1, 0, 1, 32'h0,        32'h7,        8'd4, 8'd2};
      vecs[13] = '{1, 1, 32'h10,       0, 0, 1, 0, 0, 32'h0,        32'h0,        8'd4, 8'd2};
      vecs[14] = '{1, 1, 32'h11,       0, 1, 1, 0, 1, 32'h0,        32'h10,       8'd4, 8'd3};
      vecs[15] = '{0, 0, 32'h0,        0, 0, 1, 0, 1, 32'h0,        32'h11,       8'd4, 8'd4};
      vecs[16] = '{1, 1, 32'h12,       0, 0, 1, 0, 1, 32'h0,        32'h11,       8'd4, 8'd4};
      vecs[17] = '{1, 1, 32'h13,       0, 0, 0, 0, 1, 32'h0,        32'h11,       8'd4, 8'd5};

      doReset();

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
         @(negedge clk);
         checkOutput($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
         checkOutput($sformatf("v%0d out0_valid", i), 32'(bus.out0_valid), 32'(vecs[i].e_v0));
         checkOutput($sformatf("v%0d out1_valid", i), 32'(bus.out1_valid), 32'(vecs[i].e_v1));
         if (vecs[i].e_v0) checkOutput($sformatf("v%0d out0_data", i), bus.out0_data, vecs[i].e_d0);
         if (vecs[i].e_v1) checkOutput($sformatf("v%0d out1_data", i), bus.out1_data, vecs[i].e_d1);
         checkOutput($sformatf("v%0d cnt0", i), 32'(bus.cnt0), 32'(vecs[i].e_c0));
         checkOutput($sformatf("v%0d cnt1", i), 32'(bus.cnt1), 32'(vecs[i].e_c1));
         @(posedge clk);
         #1;
      end

      // Random traffic against the queue model
      doReset();
      for (int i = 0; i < 800; i++) begin
         applyStimulus(($urandom % 4) != 0, 1'($urandom), $urandom,
                       ($urandom % 3) != 0, ($urandom % 3) == 0);
         modelCycle();
      end

      // Counter wrap: 256 back-to-back pushes into channel 0 while it drains
      doReset();
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 1'b0, 32'(i) ^ 32'hC0DE0000, 1'b1, 1'b0);
         modelCycle();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      modelCycle();
      modelCycle();
      checkOutput("wrap_cnt0", 32'(bus.cnt0), 32'd0);
      checkOutput("wrap_cnt1", 32'(bus.cnt1), 32'd0);
      checkOutput("wrap_pops0", 32'(dut_pops0), 32'd256);

      // Asynchronous reset with both channels full, dropped between edges
      applyStimulus(1'b1, 1'b0, 32'hAA000001, 1'b0, 1'b0); modelCycle();
      applyStimulus(1'b1, 1'b0, 32'hAA000002, 1'b0, 1'b0); modelCycle();
      applyStimulus(1'b1, 1'b1, 32'hBB000001, 1'b0, 1'b0); modelCycle();
      applyStimulus(1'b1, 1'b1, 32'hBB000002, 1'b0, 1'b0); modelCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      checkOutput("full_before_rst_in_ready", 32'(bus.in_ready), 32'd0);
      clrn = 1'b0;
      #1;
      checkOutput("arst_out0_valid", 32'(bus.out0_valid), 32'd0);
      checkOutput("arst_out1_valid", 32'(bus.out1_valid), 32'd0);
      checkOutput("arst_cnt0", 32'(bus.cnt0), 32'd0);
      checkOutput("arst_cnt1", 32'(bus.cnt1), 32'd0);
      checkOutput("arst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      clrn = 1'b1;
      clearModel();
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b1, 32'hCAFE0001, 1'b0, 1'b0); modelCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);        modelCycle();
      modelCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
